// File: rtl/fsm_seq_pkg.sv
// fsm_seq_pkg: shared definitions for fsm_stream_sequencer.
// Contents: sequencer state encoding, maximum pattern length, and the
// saturating increment used by the match counter.
package fsm_seq_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FSM_RST = 2'd1,
        DRIVE   = 2'd2,
        DONE    = 2'd3
    } seq_state_t;
    localparam int LEN_MAX = 64;
    // Adds one to v unless v already holds the largest w-bit value.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        return (v == (32'd1 << w) - 32'd1) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/seq_shift_reg.sv
// seq_shift_reg: pattern shift register and bit-index counter.
// Ports:
//   clk, nreset       clock, asynchronous active-low reset
//   load, data        capture data and clear the index
//   shift             shift the register one place toward bit 0
//   step              advance the bit index
//   bit0              next pattern bit to drive
//   last_bit          index has reached LEN-1
//   idx               current bit index
module seq_shift_reg #(
    parameter int LEN   = 20,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             load,
    input  logic             shift,
    input  logic             step,
    input  logic [LEN-1:0]   data,
    output logic             bit0,
    output logic             last_bit,
    output logic [IDX_W-1:0] idx
);
    logic [LEN-1:0] sr;
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sr  <= '0;
            idx <= '0;
        end else if (load) begin
            sr  <= data;
            idx <= '0;
        end else begin
            if (shift) sr <= sr >> 1;
            if (step) idx <= idx + IDX_W'(1);
        end
    end
    assign bit0     = sr[0];
    assign last_bit = idx == IDX_W'(LEN - 1);
endmodule

// File: rtl/fsm_stream_sequencer.sv
// fsm_stream_sequencer: drives a LEN-bit pattern LSB-first into a serial FSM
// and counts the cycles in which the FSM output is high.
// Ports:
//   clk, nreset        clock, asynchronous active-low reset
//   start, abort       begin a run (IDLE only) / cancel a run in progress
//   pattern_in         pattern captured on an accepted start
//   fsm_nreset, x1     registered reset and serial bit to the driven FSM
//   fsm_z              FSM output, sampled at each DRIVE edge
//   busy, done         run in progress / one-cycle completion pulse
//   match_count        saturating count of fsm_z=1 samples
//   found, first_idx   a match occurred / bit index of the first match
//   z_trace            per-bit fsm_z samples (only with SEQ_TRACE_EN defined)
module fsm_stream_sequencer
    import fsm_seq_pkg::*;
#(
    parameter int LEN   = 20,
    parameter int CNT_W = 5,
    parameter int IDX_W = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN-1:0]   pattern_in,
    output logic             fsm_nreset,
    output logic             x1,
    input  logic             fsm_z,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count,
    output logic             found,
    output logic [IDX_W-1:0] first_idx
`ifdef SEQ_TRACE_EN
    ,
    output logic [LEN-1:0]   z_trace
`endif
);
    seq_state_t       state;
    logic             bit0;
    logic             last_bit;
    logic             load;
    logic             shift;
    logic             step;
    logic [IDX_W-1:0] idx;
    // x1 is registered, so the register is shifted whenever bit0 is copied
    // into x1: on leaving FSM_RST and on every DRIVE cycle but the last.
    assign load  = state == IDLE && start;
    assign shift = state == FSM_RST || (state == DRIVE && !last_bit);
    assign step  = state == DRIVE;
    seq_shift_reg #(.LEN(LEN), .IDX_W(IDX_W)) u_sr (
        .clk      (clk),
        .nreset   (nreset),
        .load     (load),
        .shift    (shift),
        .step     (step),
        .data     (pattern_in),
        .bit0     (bit0),
        .last_bit (last_bit),
        .idx      (idx)
    );
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            fsm_nreset  <= 1'b0;
            x1          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            match_count <= '0;
            found       <= 1'b0;
            first_idx   <= '0;
        end else begin
            done       <= 1'b0;
            x1         <= 1'b0;
            fsm_nreset <= 1'b1;
            busy       <= 1'b0;
            // Every DRIVE edge samples fsm_z, including one that aborts.
            if (state == DRIVE && fsm_z) begin
                match_count <= CNT_W'(sat_inc(32'(match_count), CNT_W));
                if (!found) begin
                    found     <= 1'b1;
                    first_idx <= idx;
                end
            end
            case (state)
                IDLE: if (start) begin
                    state       <= FSM_RST;
                    fsm_nreset  <= 1'b0;
                    busy        <= 1'b1;
                    match_count <= '0;
                    found       <= 1'b0;
                    first_idx   <= '0;
                end
                FSM_RST: if (abort) state <= IDLE;
                else begin
                    state <= DRIVE;
                    busy  <= 1'b1;
                    x1    <= bit0;
                end
                DRIVE: if (abort) state <= IDLE;
                else if (last_bit) begin
                    state <= DONE;
                    done  <= 1'b1;
                end else begin
                    busy <= 1'b1;
                    x1   <= bit0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef SEQ_TRACE_EN
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) z_trace <= '0;
        else if (load) z_trace <= '0;
        else if (state == DRIVE) z_trace <= z_trace | (LEN'(fsm_z) << idx);
    end
`endif
endmodule

// File: tb/tb_fsm_stream_sequencer.sv
// tb_fsm_stream_sequencer: randomized bench for fsm_stream_sequencer with a
// per-run behavioural model; a second instance with CNT_W=3 covers saturation.
module tb_fsm_stream_sequencer;
    localparam int LEN  = 20;
    localparam int NONE = 1000;
    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [LEN-1:0] pattern_in = '0;
    logic fsm_nreset, x1, fsm_z, busy, done, found;
    logic [4:0] match_count, first_idx;
    logic s_nrst, s_x1, s_z, s_busy, s_done, s_found;
    logic [2:0] s_cnt;
    logic [4:0] s_idx;
    logic x1_d = 1'b0;
    logic s_x1_d = 1'b0;
    int mode = 0;
`ifdef SEQ_TRACE_EN
    logic [LEN-1:0] z_trace, s_trace;
`endif
    // stub FSMs: 0 echo, 1 echo delayed one cycle, 2 inverted echo
    always #5 clk = ~clk;
    always @(posedge clk) begin
        x1_d   <= x1;
        s_x1_d <= s_x1;
    end
    assign fsm_z = (mode == 0) ? x1 : (mode == 1) ? x1_d : ~x1;
    assign s_z   = (mode == 0) ? s_x1 : (mode == 1) ? s_x1_d : ~s_x1;

    fsm_stream_sequencer #(.LEN(LEN), .CNT_W(5)) dut (
        .clk(clk), .nreset(nreset), .start(start), .abort(abort),
        .pattern_in(pattern_in), .fsm_nreset(fsm_nreset), .x1(x1),
        .fsm_z(fsm_z), .busy(busy), .done(done), .match_count(match_count),
        .found(found), .first_idx(first_idx)
`ifdef SEQ_TRACE_EN
        , .z_trace(z_trace)
`endif
    );
    fsm_stream_sequencer #(.LEN(LEN), .CNT_W(3)) u_sat (
        .clk(clk), .nreset(nreset), .start(start), .abort(abort),
        .pattern_in(pattern_in), .fsm_nreset(s_nrst), .x1(s_x1),
        .fsm_z(s_z), .busy(s_busy), .done(s_done), .match_count(s_cnt),
        .found(s_found), .first_idx(s_idx)
`ifdef SEQ_TRACE_EN
        , .z_trace(s_trace)
`endif
    );

    logic e_busy, e_done, e_x1, e_nrst, e_found;
    logic [4:0] e_cnt, e_idx;
    logic [2:0] e_sat;
    logic [LEN-1:0] e_trace;
    logic [LEN-1:0] x1_log;
    int checks = 0;
    int passes = 0;
    int busy_n, done_n;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(e_busy));
            chk("done", 64'(done), 64'(e_done));
            chk("x1", 64'(x1), 64'(e_x1));
            chk("fsm_nreset", 64'(fsm_nreset), 64'(e_nrst));
            chk("match_count", 64'(match_count), 64'(e_cnt));
            chk("found", 64'(found), 64'(e_found));
            chk("first_idx", 64'(first_idx), 64'(e_idx));
            chk("sat_match_count", 64'(s_cnt), 64'(e_sat));
`ifdef SEQ_TRACE_EN
            chk("z_trace", 64'(z_trace), 64'(e_trace));
`endif
        end
    end

    // fsm_z value the stub presents in DRIVE cycle k, derived from the pattern
    function automatic logic zv(input logic [LEN-1:0] p, input int m, input int k);
        logic [LEN-1:0] t;
        t = (m == 1) ? (p << 1) : p;
        t = t >> k;
        return (m == 2) ? ~t[0] : t[0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        busy_n += int'(busy);
        done_n += int'(done);
    endtask

    task automatic go_idle();
        e_busy = 1'b0;
        e_done = 1'b0;
        e_x1   = 1'b0;
        e_nrst = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
    endtask

    // Called at the start of an IDLE cycle. ab: -1 aborts in FSM_RST, k aborts
    // in DRIVE cycle k. rk: drop nreset in DRIVE cycle rk. chain: hold start
    // high through DONE with pattern np.
    task automatic run(input logic [LEN-1:0] p, input int m, input int ab,
                       input int rk, input bit chain, input logic [LEN-1:0] np);
        int cnt;
        logic z;
        cnt = 0;
        busy_n = 0;
        done_n = 0;
        x1_log = '0;
        mode = m;
        start = 1'b1;
        pattern_in = p;
        abort = 1'($urandom_range(0, 1));
        step();
        e_busy = 1'b1; e_done = 1'b0; e_x1 = 1'b0; e_nrst = 1'b0;
        e_cnt = '0; e_sat = '0; e_found = 1'b0; e_idx = '0; e_trace = '0;
        start = 1'($urandom_range(0, 1));
        pattern_in = LEN'($urandom);
        abort = (ab == -1);
        step();
        if (ab == -1) begin
            go_idle();
            return;
        end
        for (int k = 0; k < LEN; k++) begin
            e_busy = 1'b1;
            e_nrst = 1'b1;
            e_x1 = zv(p, 0, k);
            x1_log = x1_log | (LEN'(x1) << k);
            if (rk == k) begin
                #1 nreset = 1'b0;
                start = 1'b0;
                abort = 1'b0;
                e_busy = 1'b0; e_done = 1'b0; e_x1 = 1'b0; e_nrst = 1'b0;
                e_cnt = '0; e_sat = '0; e_found = 1'b0; e_idx = '0; e_trace = '0;
                #1;
                chk("async_rst_busy", 64'(busy), 64'(0));
                chk("async_rst_fsm_nreset", 64'(fsm_nreset), 64'(0));
                @(posedge clk);
                #2 nreset = 1'b1;
                step();
                e_nrst = 1'b1;
                return;
            end
            start = (k < LEN - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            pattern_in = LEN'($urandom);
            abort = (ab == k);
            step();
            z = zv(p, m, k);
            if (z) begin
                cnt++;
                if (!e_found) begin
                    e_found = 1'b1;
                    e_idx = 5'(k);
                end
            end
            e_cnt = 5'(cnt);
            e_sat = (cnt > 7) ? 3'd7 : 3'(cnt);
            e_trace = e_trace | (LEN'(z) << k);
            if (ab == k) begin
                go_idle();
                return;
            end
        end
        e_busy = 1'b0; e_done = 1'b1; e_x1 = 1'b0; e_nrst = 1'b1;
        start = chain;
        pattern_in = np;
        abort = 1'b0;
        step();
        e_done = 1'b0;
    endtask

    initial begin
        logic [LEN-1:0] p, np;
        bit chained;
        e_busy = 1'b0; e_done = 1'b0; e_x1 = 1'b0; e_nrst = 1'b0;
        e_cnt = '0; e_sat = '0; e_found = 1'b0; e_idx = '0; e_trace = '0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 nreset = 1'b1;
        step();
        e_nrst = 1'b1;

        run(20'h00009, 0, NONE, NONE, 1'b0, '0);
        chk("p9_busy_cycles", 64'(busy_n), 64'(21));
        chk("p9_done_pulses", 64'(done_n), 64'(1));
        chk("p9_x1_sequence", 64'(x1_log), 64'h9);
        chk("p9_count", 64'(match_count), 64'(2));
        chk("p9_found", 64'(found), 64'(1));
        chk("p9_first_idx", 64'(first_idx), 64'(0));

        run(20'h80000, 0, NONE, NONE, 1'b0, '0);
        chk("msb_count", 64'(match_count), 64'(1));
        chk("msb_first_idx", 64'(first_idx), 64'(19));
        chk("msb_found", 64'(found), 64'(1));

        run(20'h00000, 0, NONE, NONE, 1'b0, '0);
        chk("zero_count", 64'(match_count), 64'(0));
        chk("zero_found", 64'(found), 64'(0));
        chk("zero_done_pulses", 64'(done_n), 64'(1));

        run(20'hFFFFF, 0, NONE, NONE, 1'b0, '0);
        chk("sat_count", 64'(s_cnt), 64'(7));
        chk("sat_first_idx", 64'(s_idx), 64'(0));
        chk("full_count", 64'(match_count), 64'(20));

        run(LEN'($urandom), 0, 5, NONE, 1'b0, '0);
        chk("abort_done_pulses", 64'(done_n), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_fsm_nreset", 64'(fsm_nreset), 64'(1));
        chk("abort_x1", 64'(x1), 64'(0));
        run(20'h00009, 0, NONE, NONE, 1'b0, '0);
        chk("after_abort_count", 64'(match_count), 64'(2));

        run(LEN'($urandom), 2, NONE, 10, 1'b0, '0);
        chk("rst_done_pulses", 64'(done_n), 64'(0));
        chk("rst_count", 64'(match_count), 64'(0));

        run(LEN'($urandom), 0, -1, NONE, 1'b0, '0);
        chk("rst_abort_done_pulses", 64'(done_n), 64'(0));

        run(20'h00003, 0, NONE, NONE, 1'b1, 20'h00005);
        run(20'h00005, 1, NONE, NONE, 1'b0, '0);
        chk("delay_first_idx", 64'(first_idx), 64'(1));
        chk("delay_count", 64'(match_count), 64'(2));
        chk("delay_found", 64'(found), 64'(1));
`ifdef SEQ_TRACE_EN
        chk("delay_z_trace", 64'(z_trace), 64'h0000A);
`endif

        chained = 1'b0;
        np = '0;
        for (int i = 0; i < 40; i++) begin
            int r, ab, rk;
            bit ch;
            p = chained ? np : LEN'($urandom);
            np = LEN'($urandom);
            r = int'($urandom_range(0, 9));
            ab = (r == 0) ? -1 : (r == 1) ? int'($urandom_range(0, LEN - 1)) : NONE;
            rk = (r == 2) ? int'($urandom_range(0, LEN - 1)) : NONE;
            ch = (r >= 7);
            run(p, int'($urandom_range(0, 2)), ab, rk, ch, np);
            chained = ch && ab == NONE && rk == NONE;
            if (!chained) begin
                start = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    abort = 1'($urandom_range(0, 1));
                    step();
                end
                abort = 1'b0;
            end
        end
        start = 1'b0;
        step();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/fsm_stream_sequencer.md
Name: fsm_stream_sequencer

Overview:
- Controller that feeds a serial bit pattern into the team's serial-input FSMs (single-bit `x1` input, single-bit `z` output) and collects the results.
- Loads a LEN-bit pattern, pulses the FSM's reset, drives one bit per clock LSB-first, and samples `z` each cycle.
- Reports the match count and the index of the first match.
- Sits between a host/bench and any FSM under exercise; replaces hand-written `x1` stimulus sequences.

Parameters:
- LEN, 20, number of pattern bits driven per run (legal range 1..64).
- CNT_W, 5, width of match_count; the counter saturates at 2^CNT_W-1.
- IDX_W, $clog2(LEN) with a minimum of 1, width of first_idx.

Ports:
- clk  in  1  system clock, rising edge.
- nreset  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  cancel a run in progress; returns to IDLE with no done pulse.
- pattern_in  in  LEN  pattern to drive; bit 0 is driven first; captured on the accepted start.
- fsm_nreset  out  1  registered reset to the driven FSM, active-low.
- x1  out  1  registered serial bit to the FSM.
- fsm_z  in  1  FSM output, sampled at each DRIVE-cycle edge.
- busy  out  1  high in FSM_RST and DRIVE.
- done  out  1  one-cycle pulse when a run completes.
- match_count  out  CNT_W  number of DRIVE cycles in which fsm_z was 1.
- found  out  1  at least one match occurred in the last run.
- first_idx  out  IDX_W  bit index k of the first match; valid when found is 1.

Behaviour:
- Reset (nreset low, asynchronous):
  - state=IDLE, fsm_nreset=0, x1=0, busy=0, done=0, match_count=0, found=0, first_idx=0, shift register and bit counter cleared.
  - Holding fsm_nreset low during system reset keeps the driven FSM in reset.
- IDLE:
  - fsm_nreset=1, x1=0, busy=0.
  - start=1 at an edge: capture pattern_in, clear match_count/found/first_idx, go to FSM_RST.
  - abort is ignored in IDLE.
- FSM_RST: exactly one cycle with fsm_nreset=0, x1=0, busy=1; then go to DRIVE.
- DRIVE: LEN cycles, numbered k=0..LEN-1.
  - During cycle k: x1 = captured pattern bit k, fsm_nreset=1.
  - At the edge ending cycle k: if fsm_z=1, match_count increments, saturating.
  - If fsm_z=1 and found=0 at that edge: found<=1 and first_idx<=k.
  - After cycle LEN-1, go to DONE.
- DONE: done=1 for one cycle, busy=0, x1=0; then go to IDLE.
- Results (match_count, found, first_idx) hold until the next accepted start.
- Latency:
  - If start is sampled at edge E0, FSM_RST spans E0..E1 and DRIVE spans E1..E(LEN+1).
  - done is high in the cycle after edge E(LEN+1).
- Boundary conditions:
  - start while busy or in DONE: ignored; a start held high in DONE is accepted in the following IDLE cycle.
  - abort in FSM_RST or DRIVE: next state IDLE, x1=0, fsm_nreset=1, no done pulse. Partial results remain visible.
  - abort and start in the same cycle while busy: abort wins. start is not re-sampled until IDLE.
  - Saturation: match_count stops at 2^CNT_W-1 and does not wrap.
  - LEN=1: DRIVE lasts one cycle and first_idx is 0.
  - nreset asserted mid-run: immediate return to the reset values above, with no done pulse.
- fsm_z is used only at DRIVE edges. Its value in any other state has no effect.

Optional Feature:
- Macro SEQ_TRACE_EN.
- Defined:
  - Adds output z_trace [LEN-1:0]. Bit k holds the fsm_z value sampled at the end of DRIVE cycle k.
  - z_trace is cleared on an accepted start and on reset, and holds after done.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Shared package fsm_seq_pkg holds:
  - state enum: IDLE=0, FSM_RST=1, DRIVE=2, DONE=3 (2 bits).
  - LEN_MAX=64.
  - helper function for the saturating increment.
- One natural sub-module: seq_shift_reg. It provides the LEN-bit load/shift register and the bit-index counter, exposing bit0 and last_bit. The top-level FSM and result capture stay in fsm_stream_sequencer.

Test Plan:
- Echo stub (fsm_z=x1), LEN=20, pattern_in=20'h00009, start one cycle:
  - busy high for 21 cycles, done pulse one cycle later.
  - match_count=2, found=1, first_idx=0.
  - x1 sequence 1,0,0,1,0…0.
- Echo stub, pattern_in=20'h80000 -> match_count=1, first_idx=19, found=1. pattern_in=0 -> match_count=0, found=0, done still pulses.
- Saturation: CNT_W=3, echo stub, pattern_in=20'hFFFFF -> match_count=7 (no wrap), first_idx=0.
- abort asserted in DRIVE cycle 5:
  - no done pulse, busy=0 next cycle.
  - fsm_nreset=1 and x1=0.
  - a subsequent start runs normally.
- nreset pulled low in DRIVE cycle 10 -> all outputs at reset values asynchronously, fsm_nreset=0. start ignored while busy; FSM_RST shows fsm_nreset=0 for exactly one cycle.
- SEQ_TRACE_EN defined, stub fsm_z = x1 delayed one cycle, pattern_in=20'h00005 -> z_trace=20'h0000A, first_idx=1.
